// File: rtl/enum_type.sv
// Shared event encoding between the input controller and the tetris core.
package enum_type;
  typedef enum logic [3:0] {
    NOEVENT    = 4'd0,
    LEFT       = 4'd1,
    RIGHT      = 4'd2,
    DOWN       = 4'd3,
    ROTATE     = 4'd4,
    ROTATE_REV = 4'd5,
    DROP       = 4'd6,
    HOLD       = 4'd7,
    BAR        = 4'd8
  } control_type;
endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Button/level inputs and the event stream between the input controller and the core.
interface tetris_input_ctrl_if;
  import enum_type::*;

  logic [6:0]  btn;
  logic [3:0]  level;
  logic        ready;
  control_type ctrl;
  logic        start_mode;

  // master: the event producer; slave: the core side that supplies buttons and ready
  modport master (input btn, level, ready, output ctrl, start_mode);
  modport slave  (output btn, level, ready, input ctrl, start_mode);
endinterface

// File: rtl/tetris_input_ctrl.sv
// Turns button edges, auto-repeat and gravity into single-cycle control events,
// buffering them as pending flags until the core can accept one.
module tetris_input_ctrl
  import enum_type::*;
#(
  parameter int unsigned GRAV_BASE   = 50_000_000,
  parameter int unsigned GRAV_STEP   = 4_000_000,
  parameter int unsigned GRAV_MIN    = 5_000_000,
  parameter int unsigned DAS_DELAY   = 20_000_000,
  parameter int unsigned DAS_RATE    = 5_000_000,
  parameter int unsigned IDLE_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  tetris_input_ctrl_if.master bus
);

  localparam int GCW = $clog2(GRAV_BASE + 1);
  localparam int DCW = $clog2(DAS_DELAY + 1);
  localparam int ICW = $clog2(IDLE_CYCLES + 1);

  localparam int B_LEFT    = 0;
  localparam int B_RIGHT   = 1;
  localparam int B_DOWN    = 2;
  localparam int B_DROP    = 3;
  localparam int B_ROT     = 4;
  localparam int B_ROT_REV = 5;
  localparam int B_HOLD    = 6;

  logic [6:0]     btn_s_reg, btn_q_reg;
  logic [6:0]     pend_reg, pend_next;
  logic           grav_pend_reg, grav_pend_next;
  logic [GCW-1:0] grav_cnt_reg;
  logic [3:0]     level_reg;
  logic [ICW-1:0] idle_cnt_reg, idle_cnt_next;
  logic           start_mode_reg, start_mode_next;
  control_type    ctrl_reg, ctrl_next;

  logic [6:0]  press, set_vec, avail, issue_vec;
  logic [2:0]  das_rep;
  logic [31:0] grav_sub, grav_period;
  logic        grav_expire, eligible, issued, issue_down;

  // Auto-repeat: counter holds the cycles since press, folding back by DAS_RATE after each repeat
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_das
    logic [DCW-1:0] das_cnt_reg;
    always_ff @(posedge clk) begin
      if (reset || !btn_s_reg[gi])
        das_cnt_reg <= '0;
      else if (das_cnt_reg == DCW'(DAS_DELAY))
        das_cnt_reg <= DCW'(DAS_DELAY - DAS_RATE + 1);
      else
        das_cnt_reg <= das_cnt_reg + 1'b1;
    end
    assign das_rep[gi] = btn_s_reg[gi] && (das_cnt_reg == DCW'(DAS_DELAY));
  end

  // Compare before subtracting so high levels cannot wrap the period
  assign grav_sub    = 32'(level_reg) * GRAV_STEP;
  assign grav_period = (grav_sub + GRAV_MIN >= GRAV_BASE) ? GRAV_MIN : GRAV_BASE - grav_sub;
  assign grav_expire = !start_mode_reg && (32'(grav_cnt_reg) == grav_period - 32'd1);

  always_comb begin
    press     = btn_s_reg & ~btn_q_reg;
    set_vec   = press | {4'b0000, das_rep};
    avail     = pend_reg | set_vec;
    avail[B_DOWN] = avail[B_DOWN] | grav_pend_reg | grav_expire;
    eligible  = (bus.ready || start_mode_reg) && (ctrl_reg == NOEVENT);
    issue_vec = '0;
    ctrl_next = NOEVENT;
    if (eligible) begin
      if (avail[B_DROP]) begin
        issue_vec[B_DROP] = 1'b1;    ctrl_next = DROP;
      end else if (avail[B_HOLD]) begin
        issue_vec[B_HOLD] = 1'b1;    ctrl_next = HOLD;
      end else if (avail[B_ROT]) begin
        issue_vec[B_ROT] = 1'b1;     ctrl_next = ROTATE;
      end else if (avail[B_ROT_REV]) begin
        issue_vec[B_ROT_REV] = 1'b1; ctrl_next = ROTATE_REV;
      end else if (avail[B_LEFT]) begin
        issue_vec[B_LEFT] = 1'b1;    ctrl_next = LEFT;
      end else if (avail[B_RIGHT]) begin
        issue_vec[B_RIGHT] = 1'b1;   ctrl_next = RIGHT;
      end else if (avail[B_DOWN]) begin
        issue_vec[B_DOWN] = 1'b1;    ctrl_next = DOWN;
      end
    end
    issued     = |issue_vec;
    issue_down = issue_vec[B_DOWN];

    // A press on a flag that was already pending survives the issue of that flag
    pend_next = ((pend_reg | set_vec) & ~issue_vec) | (pend_reg & set_vec & issue_vec);

    if (issued || bus.ready)
      idle_cnt_next = '0;
    else if (idle_cnt_reg == ICW'(IDLE_CYCLES))
      idle_cnt_next = idle_cnt_reg;
    else
      idle_cnt_next = idle_cnt_reg + 1'b1;
    start_mode_next = (idle_cnt_next == ICW'(IDLE_CYCLES));

    if ((start_mode_next && !start_mode_reg) || issue_down)
      grav_pend_next = 1'b0;
    else
      grav_pend_next = grav_pend_reg | grav_expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s_reg      <= '0;
      btn_q_reg      <= '0;
      pend_reg       <= '0;
      grav_pend_reg  <= 1'b0;
      grav_cnt_reg   <= '0;
      level_reg      <= '0;
      idle_cnt_reg   <= '0;
      start_mode_reg <= 1'b0;
      ctrl_reg       <= NOEVENT;
    end else begin
      btn_s_reg      <= bus.btn;
      btn_q_reg      <= btn_s_reg;
      pend_reg       <= pend_next;
      grav_pend_reg  <= grav_pend_next;
      idle_cnt_reg   <= idle_cnt_next;
      start_mode_reg <= start_mode_next;
      ctrl_reg       <= ctrl_next;
      if (issue_down || grav_expire) begin
        grav_cnt_reg <= '0;
        level_reg    <= bus.level;
      end else if (!start_mode_reg) begin
        grav_cnt_reg <= grav_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.ctrl       = ctrl_reg;
  assign bus.start_mode = start_mode_reg;

endmodule
